// File: rtl/led_mux_pwm.sv
// LED source selector: validates a one-hot active-low select, inserts a blanking
// gap on channel changes, and PWM-dims the registered active-low panel output.
module led_mux_pwm #(
    parameter int N_CH      = 7,
    parameter int LED_W     = 4,
    parameter int BLANK_CYC = 4,
    parameter int PWM_W     = 4,
    parameter int CH_W      = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sel_n,
    input  logic [N_CH*LED_W-1:0]   led_in,
    input  logic [PWM_W-1:0]        bright,
    output logic [LED_W-1:0]        pio_led,
    output logic [CH_W-1:0]         active_ch,
    output logic                    ch_on,
    output logic                    sel_err
);

    typedef enum logic [1:0] {BLANK, SHOW, GAP} state_t;

    state_t             state, next_state;
    logic [CH_W-1:0]    next_ch;
    logic [7:0]         gap_cnt, next_gap;
    logic               next_err;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [4:0]         zero_cnt;
    logic [CH_W-1:0]    idx;
    logic               sel_ok;
    logic               lit;
    logic [LED_W-1:0]   cur_pat;

    always_comb begin
        zero_cnt = 5'd0;
        idx      = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!sel_n[i]) begin
                zero_cnt = zero_cnt + 5'd1;
                idx      = CH_W'(i);
            end
        end
        sel_ok = (zero_cnt == 5'd1);
    end

    // Pattern of the latched channel; the out-of-range default never occurs in use.
    always_comb begin
        cur_pat = '1;
        for (int i = 0; i < N_CH; i++) begin
            if (active_ch == CH_W'(i)) begin
                cur_pat = led_in[i*LED_W +: LED_W];
            end
        end
    end

    assign lit   = (&bright) || (pwm_cnt < bright);
    assign ch_on = (state == SHOW);

    always_comb begin
        next_state = state;
        next_ch    = active_ch;
        next_gap   = gap_cnt;
        next_err   = 1'b0;
        case (state)
            BLANK: begin
                if (sel_ok) begin
                    next_ch    = idx;
                    next_state = SHOW;
                end
            end
            SHOW: begin
                if (!sel_ok) begin
                    next_state = BLANK;
                    next_err   = 1'b1;
                end else if (idx != active_ch) begin
                    next_state = GAP;
                    next_gap   = 8'(BLANK_CYC - 1);
                end
            end
            GAP: begin
                // An invalid select aborts the gap before the counter is considered.
                if (!sel_ok) begin
                    next_state = BLANK;
                    next_err   = 1'b1;
                end else if (gap_cnt != 8'd0) begin
                    next_gap = gap_cnt - 8'd1;
                end else begin
                    next_ch    = idx;
                    next_state = SHOW;
                end
            end
            default: next_state = BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BLANK;
            active_ch <= '0;
            gap_cnt   <= 8'd0;
            sel_err   <= 1'b0;
            pwm_cnt   <= '0;
            pio_led   <= '1;
        end else begin
            state     <= next_state;
            active_ch <= next_ch;
            gap_cnt   <= next_gap;
            sel_err   <= next_err;
            pwm_cnt   <= pwm_cnt + PWM_W'(1);
            pio_led   <= (state == SHOW && lit) ? cur_pat : '1;
        end
    end

endmodule

// File: tb/tb_led_mux_pwm.sv
// Bench for led_mux_pwm: edge-indexed reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_led_mux_pwm;

    localparam int N_CH      = 7;
    localparam int LED_W     = 4;
    localparam int BLANK_CYC = 4;
    localparam int PWM_W     = 4;
    localparam int CH_W      = $clog2(N_CH);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       sel_n;
    logic [N_CH*LED_W-1:0] led_in;
    logic [PWM_W-1:0]      bright;
    logic [LED_W-1:0]      pio_led;
    logic [CH_W-1:0]       active_ch;
    logic                  ch_on;
    logic                  sel_err;

    int n_cmp = 0;
    int n_bad = 0;

    led_mux_pwm #(.N_CH(N_CH), .LED_W(LED_W), .BLANK_CYC(BLANK_CYC),
                  .PWM_W(PWM_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst), .sel_n(sel_n), .led_in(led_in), .bright(bright),
        .pio_led(pio_led), .active_ch(active_ch), .ch_on(ch_on), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes 0=blank 1=show 2=gap; the gap ends on an absolute edge number.
    int         m_mode = 0;
    int         m_ch = 0;
    int         m_pwm = 0;
    int         m_edge = 0;
    int         m_gap_end = 0;
    bit         m_valid = 0;
    logic [3:0] e_led = 4'hF;
    logic       e_err = 1'b0;
    int         zeros, sidx;
    bit         ok, m_lit;

    always @(posedge clk) begin
        zeros = 0;
        sidx  = 0;
        for (int i = 0; i < N_CH; i++) if (sel_n[i] == 1'b0) begin zeros++; sidx = i; end
        ok    = (zeros == 1);
        m_lit = (bright == 4'hF) || (m_pwm < int'(bright));
        if (rst) begin
            m_mode = 0; m_ch = 0; m_pwm = 0; e_led = 4'hF; e_err = 1'b0; m_valid = 1;
        end else begin
            e_led = (m_mode == 1 && m_lit) ? led_in[m_ch*LED_W +: LED_W] : 4'hF;
            e_err = 1'b0;
            if (m_mode == 0) begin
                if (ok) begin m_ch = sidx; m_mode = 1; end
            end else if (!ok) begin
                m_mode = 0; e_err = 1'b1;
            end else if (m_mode == 1) begin
                if (sidx != m_ch) begin m_mode = 2; m_gap_end = m_edge + BLANK_CYC; end
            end else if (m_edge == m_gap_end) begin
                m_ch = sidx; m_mode = 1;
            end
            m_pwm = (m_pwm + 1) % 16;
        end
        m_edge++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pio_led", 32'(pio_led), 32'(e_led));
            check("model_active_ch", 32'(active_ch), 32'(m_ch));
            check("model_ch_on", 32'(ch_on), 32'(m_mode == 1));
            check("model_sel_err", 32'(sel_err), 32'(e_err));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int lit_cnt;

    initial begin
        led_in = '0;
        led_in[0*4 +: 4] = 4'b1110;
        led_in[1*4 +: 4] = 4'b1101;
        led_in[2*4 +: 4] = 4'b0101;
        led_in[3*4 +: 4] = 4'b1001;
        led_in[4*4 +: 4] = 4'b0110;
        led_in[5*4 +: 4] = 4'b0011;
        led_in[6*4 +: 4] = 4'b0000;
        bright = 4'hF;
        sel_n  = 7'b1111011;
        rst    = 1'b1;
        step(2);
        check("rst_pio", 32'(pio_led), 32'hF);
        check("rst_ch", 32'(active_ch), 0);
        check("rst_ch_on", 32'(ch_on), 0);
        check("rst_err", 32'(sel_err), 0);

        rst = 1'b0; sel_n = 7'b1111111;
        step(3);
        check("idle_pio", 32'(pio_led), 32'hF);
        check("idle_err", 32'(sel_err), 0);

        // Select channel 2
        sel_n = 7'b1111011;
        step();
        check("sel_ch", 32'(active_ch), 2);
        check("sel_ch_on", 32'(ch_on), 1);
        check("sel_pio_t", 32'(pio_led), 32'hF);
        step();
        check("sel_pio_t1", 32'(pio_led), 32'b0101);

        // Switch to channel 5
        sel_n = 7'b1011111;
        step();
        check("sw_pio_t", 32'(pio_led), 32'b0101);
        for (int k = 1; k <= BLANK_CYC; k++) begin
            check("sw_ch_on_gap", 32'(ch_on), 0);
            step();
            check("sw_pio_blank", 32'(pio_led), 32'hF);
        end
        check("sw_ch", 32'(active_ch), 5);
        step();
        check("sw_pio_new", 32'(pio_led), 32'b0011);

        // Invalid select during SHOW
        sel_n = 7'b1110011;
        step();
        check("inv_show_err", 32'(sel_err), 1);
        check("inv_show_ch_on", 32'(ch_on), 0);
        step();
        check("inv_show_err_drop", 32'(sel_err), 0);
        check("inv_show_pio", 32'(pio_led), 32'hF);

        // Invalid select during GAP
        sel_n = 7'b1011111;
        step(2);
        sel_n = 7'b1111011;
        step(2);
        sel_n = 7'b1110011;
        step();
        check("inv_gap_err", 32'(sel_err), 1);
        check("inv_gap_ch_on", 32'(ch_on), 0);
        step();
        check("inv_gap_err_drop", 32'(sel_err), 0);
        check("inv_gap_pio", 32'(pio_led), 32'hF);

        // Return to the old channel during the gap
        sel_n = 7'b1111011;
        step(2);
        sel_n = 7'b1011111;
        step(2);
        sel_n = 7'b1111011;
        step(BLANK_CYC);
        check("ret_ch", 32'(active_ch), 2);
        check("ret_ch_on", 32'(ch_on), 1);

        // PWM dimming on channel 2
        bright = 4'd4;
        lit_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (pio_led == 4'b0101) lit_cnt++;
        end
        check("pwm_bright4", 32'(lit_cnt), 8);
        bright = 4'd0;
        lit_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (pio_led != 4'hF) lit_cnt++;
        end
        check("pwm_bright0", 32'(lit_cnt), 0);
        bright = 4'hF;
        step();
        lit_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (pio_led == 4'b0101) lit_cnt++;
        end
        check("pwm_bright15", 32'(lit_cnt), 16);

        // Reset in the middle of a gap (gap counter at 2) with a valid new select
        sel_n = 7'b1011111;
        step(2);
        rst = 1'b1; sel_n = 7'b0111111;
        step();
        check("mid_rst_pio", 32'(pio_led), 32'hF);
        check("mid_rst_ch", 32'(active_ch), 0);
        check("mid_rst_ch_on", 32'(ch_on), 0);
        check("mid_rst_err", 32'(sel_err), 0);
        rst = 1'b0; sel_n = 7'b1111111;
        step(BLANK_CYC + 2);
        check("post_rst_ch", 32'(active_ch), 0);
        check("post_rst_ch_on", 32'(ch_on), 0);
        check("post_rst_pio", 32'(pio_led), 32'hF);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
